// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operations and
// the packed ID/EX control payload.
package mips_pkg;

    localparam int unsigned WORD_SIZE_DEF = 32;
    localparam int unsigned LINK_REG_DEF  = 31;
    localparam int unsigned REG_IDX_W     = 5;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned INSN_W        = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        alu_op_e              alu_op;
        logic                 alu_src;
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 reg_wr;
        logic                 mem_to_reg;
        logic                 link;
        logic                 illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_if.sv
// IF/ID, writeback, redirect and ID/EX signal bundle around the decode stage.
interface decode_if import mips_pkg::*; #(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
);
    logic [WORD_SIZE-1:0] pc_if_id;
    logic [INSN_W-1:0]    ir_if_id;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] wb_reg;
    logic [WORD_SIZE-1:0] wb_data;

    logic                 jump;
    logic [WORD_SIZE-1:0] addr;

    logic [WORD_SIZE-1:0] pc_id_ex;
    logic [WORD_SIZE-1:0] rs_id_ex;
    logic [WORD_SIZE-1:0] rt_id_ex;
    logic [WORD_SIZE-1:0] imm_id_ex;
    logic [REG_IDX_W-1:0] dst_id_ex;
    alu_op_e              alu_op_id_ex;
    logic                 alu_src_id_ex;
    logic                 mem_rd_id_ex;
    logic                 mem_wr_id_ex;
    logic                 reg_wr_id_ex;
    logic                 mem_to_reg_id_ex;
    logic                 link_id_ex;
    logic                 illegal;

    modport slave (
        input  pc_if_id, ir_if_id, wb_en, wb_reg, wb_data,
        output jump, addr,
        output pc_id_ex, rs_id_ex, rt_id_ex, imm_id_ex, dst_id_ex, alu_op_id_ex,
        output alu_src_id_ex, mem_rd_id_ex, mem_wr_id_ex, reg_wr_id_ex,
        output mem_to_reg_id_ex, link_id_ex, illegal
    );

    modport master (
        output pc_if_id, ir_if_id, wb_en, wb_reg, wb_data,
        input  jump, addr,
        input  pc_id_ex, rs_id_ex, rt_id_ex, imm_id_ex, dst_id_ex, alu_op_id_ex,
        input  alu_src_id_ex, mem_rd_id_ex, mem_wr_id_ex, reg_wr_id_ex,
        input  mem_to_reg_id_ex, link_id_ex, illegal
    );
endinterface

// File: rtl/regfile.sv
// 32-entry register file: two combinational reads with write bypass, one
// synchronous write, asynchronous clear; r0 is hardwired to zero.
module regfile import mips_pkg::*; #(
    parameter int unsigned WIDTH = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_b,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata
);
    logic [WIDTH-1:0] mem_q [NUM_REGS];
    logic [WIDTH-1:0] mem_d [NUM_REGS];
    logic             wr_ok;

    assign wr_ok = we && (waddr != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    // Same-cycle writeback wins over the stored value
    always_comb begin
        rdata_a = mem_q[raddr_a];
        if (wr_ok && (waddr == raddr_a)) rdata_a = wdata;
        if (raddr_a == '0) rdata_a = '0;

        rdata_b = mem_q[raddr_b];
        if (wr_ok && (waddr == raddr_b)) rdata_b = wdata;
        if (raddr_b == '0) rdata_b = '0;
    end
endmodule

// File: rtl/decode.sv
// MIPS ID stage: register file read, control decode into ID/EX registers and
// combinational jump/branch redirect back to fetch.
module decode import mips_pkg::*; #(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned LINK_REG  = LINK_REG_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    decode_if.slave  bus
);
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [REG_IDX_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [4:0]           shamt;
    logic [15:0]          imm16;
    logic [WORD_SIZE-1:0] rs_val, rt_val;
    logic [WORD_SIZE-1:0] imm_sext, imm_zext, imm_lui, shamt_zext;
    logic [WORD_SIZE-1:0] pc_plus1, br_target, j_target;

    logic [WORD_SIZE-1:0] pc_d, pc_q, rs_d, rs_q, rt_d, rt_q, imm_d, imm_q;
    ctrl_t                ctrl_d, ctrl_q;
    logic                 illegal_c;
    logic                 jump_c;
    logic [WORD_SIZE-1:0] addr_c;

    assign opcode = bus.ir_if_id[31:26];
    assign rs_idx = bus.ir_if_id[25:21];
    assign rt_idx = bus.ir_if_id[20:16];
    assign rd_idx = bus.ir_if_id[15:11];
    assign shamt  = bus.ir_if_id[10:6];
    assign funct  = bus.ir_if_id[5:0];
    assign imm16  = bus.ir_if_id[15:0];

    assign imm_sext   = {{(WORD_SIZE-16){imm16[15]}}, imm16};
    assign imm_zext   = WORD_SIZE'(imm16);
    assign imm_lui    = WORD_SIZE'(imm16) << 16;
    assign shamt_zext = WORD_SIZE'(shamt);
    assign pc_plus1   = bus.pc_if_id + WORD_SIZE'(1);
    assign br_target  = bus.pc_if_id + imm_sext;
    assign j_target   = {bus.pc_if_id[WORD_SIZE-1:26], bus.ir_if_id[25:0]};

    regfile #(.WIDTH(WORD_SIZE)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs_idx),
        .rdata_a (rs_val),
        .raddr_b (rt_idx),
        .rdata_b (rt_val),
        .we      (bus.wb_en),
        .waddr   (bus.wb_reg),
        .wdata   (bus.wb_data)
    );

    always_comb begin
        ctrl_d    = '0;
        pc_d      = bus.pc_if_id;
        rs_d      = rs_val;
        rt_d      = rt_val;
        imm_d     = '0;
        illegal_c = 1'b0;
        jump_c    = 1'b0;
        addr_c    = '0;

        case (opcode)
            OP_RTYPE: begin
                ctrl_d.dst    = rd_idx;
                ctrl_d.reg_wr = (rd_idx != '0);
                case (funct)
                    FN_ADDU: ctrl_d.alu_op = ALU_ADD;
                    FN_SUBU: ctrl_d.alu_op = ALU_SUB;
                    FN_AND:  ctrl_d.alu_op = ALU_AND;
                    FN_OR:   ctrl_d.alu_op = ALU_OR;
                    FN_XOR:  ctrl_d.alu_op = ALU_XOR;
                    FN_NOR:  ctrl_d.alu_op = ALU_NOR;
                    FN_SLT:  ctrl_d.alu_op = ALU_SLT;
                    FN_SLTU: ctrl_d.alu_op = ALU_SLTU;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ctrl_d.alu_op  = (funct == FN_SLL) ? ALU_SLL :
                                         (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                        ctrl_d.alu_src = 1'b1;
                        imm_d          = shamt_zext;
                    end
                    FN_JR: begin
                        ctrl_d.dst    = '0;
                        ctrl_d.reg_wr = 1'b0;
                        jump_c        = 1'b1;
                        addr_c        = rs_val;
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                ctrl_d.dst     = rt_idx;
                ctrl_d.reg_wr  = (rt_idx != '0);
                ctrl_d.alu_src = 1'b1;
                imm_d          = imm_sext;
                case (opcode)
                    OP_SLTI:  ctrl_d.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl_d.alu_op = ALU_SLTU;
                    OP_ANDI:  begin ctrl_d.alu_op = ALU_AND; imm_d = imm_zext; end
                    OP_ORI:   begin ctrl_d.alu_op = ALU_OR;  imm_d = imm_zext; end
                    OP_XORI:  begin ctrl_d.alu_op = ALU_XOR; imm_d = imm_zext; end
                    OP_LUI:   begin ctrl_d.alu_op = ALU_LUI; imm_d = imm_lui;  end
                    OP_LW: begin
                        ctrl_d.mem_rd     = 1'b1;
                        ctrl_d.mem_to_reg = 1'b1;
                    end
                    default:  ctrl_d.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.mem_wr  = 1'b1;
                imm_d          = imm_sext;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_d.alu_op = ALU_SUB;
                imm_d         = imm_sext;
                jump_c        = (opcode == OP_BEQ) ? (rs_val == rt_val) : (rs_val != rt_val);
                addr_c        = jump_c ? br_target : '0;
            end
            OP_J: begin
                jump_c = 1'b1;
                addr_c = j_target;
            end
            // Link value rides on the rs operand so EX computes rs + 0
            OP_JAL: begin
                ctrl_d.dst     = REG_IDX_W'(LINK_REG);
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.link    = 1'b1;
                ctrl_d.alu_src = 1'b1;
                rs_d           = pc_plus1;
                jump_c         = 1'b1;
                addr_c         = j_target;
            end
            default: illegal_c = 1'b1;
        endcase

        if (illegal_c) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
            imm_d          = '0;
            jump_c         = 1'b0;
            addr_c         = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
        end else begin
            pc_q   <= pc_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            imm_q  <= imm_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.jump             = jump_c & rst_n;
    assign bus.addr             = rst_n ? addr_c : '0;
    assign bus.pc_id_ex         = pc_q;
    assign bus.rs_id_ex         = rs_q;
    assign bus.rt_id_ex         = rt_q;
    assign bus.imm_id_ex        = imm_q;
    assign bus.dst_id_ex        = ctrl_q.dst;
    assign bus.alu_op_id_ex     = ctrl_q.alu_op;
    assign bus.alu_src_id_ex    = ctrl_q.alu_src;
    assign bus.mem_rd_id_ex     = ctrl_q.mem_rd;
    assign bus.mem_wr_id_ex     = ctrl_q.mem_wr;
    assign bus.reg_wr_id_ex     = ctrl_q.reg_wr;
    assign bus.mem_to_reg_id_ex = ctrl_q.mem_to_reg;
    assign bus.link_id_ex       = ctrl_q.link;
    assign bus.illegal          = ctrl_q.illegal;
endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage; expected values are hand-computed.
module tb_decode;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    decode_if #(.WORD_SIZE(32)) bus ();

    decode #(.WORD_SIZE(32), .LINK_REG(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                         input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.pc_if_id = 32'h0;
        bus.ir_if_id = i_op(6'h09, 0, 1, 16'd5);
        bus.wb_en    = 1'b0;
        bus.wb_reg   = 5'd0;
        bus.wb_data  = 32'h0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reg_wr", 32'(bus.reg_wr_id_ex), 32'd0);
        chk("rst_dst",    32'(bus.dst_id_ex), 32'd0);
        chk("rst_imm",    bus.imm_id_ex, 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_jump",   32'(bus.jump), 32'd0);
        bus.ir_if_id = 32'h0800_0010;
        #1;
        chk("rst_jump_j", 32'(bus.jump), 32'd0);
        bus.ir_if_id = i_op(6'h09, 0, 1, 16'd5);
        rst_n = 1'b1;

        tick();
        chk("addiu_reg_wr", 32'(bus.reg_wr_id_ex), 32'd1);
        chk("addiu_dst",    32'(bus.dst_id_ex), 32'd1);
        chk("addiu_imm",    bus.imm_id_ex, 32'd5);
        chk("addiu_aluop",  32'(bus.alu_op_id_ex), 32'd0);
        chk("addiu_src",    32'(bus.alu_src_id_ex), 32'd1);

        // Writeback r2 while ADDU r3,r2,r0 reads it
        bus.wb_en = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 32'h1234;
        bus.ir_if_id = r_op(2, 0, 3, 0, 6'h21);
        tick();
        chk("bypass_rs",  bus.rs_id_ex, 32'h1234);
        chk("addu_dst",   32'(bus.dst_id_ex), 32'd3);
        chk("addu_src",   32'(bus.alu_src_id_ex), 32'd0);

        bus.wb_reg = 5'd0; bus.wb_data = 32'hFFFF;
        bus.ir_if_id = r_op(0, 2, 3, 0, 6'h21);
        tick();
        chk("r0_bypass",  bus.rs_id_ex, 32'h0);
        chk("r2_stored",  bus.rt_id_ex, 32'h1234);
        bus.wb_en = 1'b0;
        bus.ir_if_id = r_op(0, 0, 3, 0, 6'h21);
        tick();
        chk("r0_after",   bus.rs_id_ex, 32'h0);

        // Branches at pc 0x10
        bus.pc_if_id = 32'h10;
        bus.ir_if_id = i_op(6'h04, 1, 1, 16'hFFFE);
        #1;
        chk("beq_jump", 32'(bus.jump), 32'd1);
        chk("beq_addr", bus.addr, 32'h0E);
        tick();
        chk("beq_reg_wr", 32'(bus.reg_wr_id_ex), 32'd0);
        chk("beq_imm",    bus.imm_id_ex, 32'hFFFF_FFFE);
        bus.ir_if_id = i_op(6'h05, 1, 1, 16'hFFFE);
        #1;
        chk("bne_nt_jump", 32'(bus.jump), 32'd0);
        chk("bne_nt_addr", bus.addr, 32'h0);
        bus.ir_if_id = i_op(6'h05, 2, 0, 16'h0003);
        #1;
        chk("bne_t_jump", 32'(bus.jump), 32'd1);
        chk("bne_t_addr", bus.addr, 32'h13);
        tick();

        // JAL with maximal target
        bus.pc_if_id = 32'h0400_0001;
        bus.ir_if_id = 32'h0FFF_FFFF;
        #1;
        chk("jal_jump", 32'(bus.jump), 32'd1);
        chk("jal_addr", bus.addr, 32'h07FF_FFFF);
        tick();
        chk("jal_dst",    32'(bus.dst_id_ex), 32'd31);
        chk("jal_reg_wr", 32'(bus.reg_wr_id_ex), 32'd1);
        chk("jal_link",   32'(bus.link_id_ex), 32'd1);
        chk("jal_rs",     bus.rs_id_ex, 32'h0400_0002);

        // JR r5 after writing r5=0x40
        bus.wb_en = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'h40;
        bus.ir_if_id = 32'h0;
        tick();
        bus.wb_en = 1'b0;
        bus.ir_if_id = r_op(5, 0, 0, 0, 6'h08);
        #1;
        chk("jr_jump", 32'(bus.jump), 32'd1);
        chk("jr_addr", bus.addr, 32'h40);
        tick();
        chk("jr_reg_wr", 32'(bus.reg_wr_id_ex), 32'd0);
        chk("jr_dst",    32'(bus.dst_id_ex), 32'd0);

        // Immediate extension
        bus.ir_if_id = i_op(6'h0D, 0, 4, 16'h8000);
        tick();
        chk("ori_imm",   bus.imm_id_ex, 32'h0000_8000);
        chk("ori_aluop", 32'(bus.alu_op_id_ex), 32'd3);
        bus.ir_if_id = i_op(6'h09, 0, 4, 16'h8000);
        tick();
        chk("addiu_sext", bus.imm_id_ex, 32'hFFFF_8000);
        bus.ir_if_id = i_op(6'h0F, 0, 4, 16'hABCD);
        tick();
        chk("lui_imm",   bus.imm_id_ex, 32'hABCD_0000);
        chk("lui_aluop", 32'(bus.alu_op_id_ex), 32'd11);

        bus.ir_if_id = r_op(0, 7, 6, 4, 6'h00);
        tick();
        chk("sll_imm",   bus.imm_id_ex, 32'd4);
        chk("sll_src",   32'(bus.alu_src_id_ex), 32'd1);
        chk("sll_aluop", 32'(bus.alu_op_id_ex), 32'd8);
        chk("sll_dst",   32'(bus.dst_id_ex), 32'd6);

        bus.ir_if_id = i_op(6'h23, 2, 8, 16'hFFFC);
        tick();
        chk("lw_mem_rd", 32'(bus.mem_rd_id_ex), 32'd1);
        chk("lw_m2r",    32'(bus.mem_to_reg_id_ex), 32'd1);
        chk("lw_dst",    32'(bus.dst_id_ex), 32'd8);
        chk("lw_rs",     bus.rs_id_ex, 32'h1234);
        bus.ir_if_id = i_op(6'h2B, 2, 8, 16'h0004);
        tick();
        chk("sw_mem_wr", 32'(bus.mem_wr_id_ex), 32'd1);
        chk("sw_reg_wr", 32'(bus.reg_wr_id_ex), 32'd0);
        chk("sw_dst",    32'(bus.dst_id_ex), 32'd0);

        // Illegal opcode then NOP
        bus.ir_if_id = 32'hFC00_0000;
        #1;
        chk("ill_jump", 32'(bus.jump), 32'd0);
        tick();
        chk("ill_flag",   32'(bus.illegal), 32'd1);
        chk("ill_reg_wr", 32'(bus.reg_wr_id_ex), 32'd0);
        chk("ill_mem_wr", 32'(bus.mem_wr_id_ex), 32'd0);
        chk("ill_mem_rd", 32'(bus.mem_rd_id_ex), 32'd0);
        bus.ir_if_id = 32'h0;
        tick();
        chk("nop_illegal", 32'(bus.illegal), 32'd0);
        chk("nop_reg_wr",  32'(bus.reg_wr_id_ex), 32'd0);
        bus.ir_if_id = r_op(1, 2, 3, 0, 6'h3F);
        tick();
        chk("ill_funct", 32'(bus.illegal), 32'd1);

        // Asynchronous reset mid-stream
        bus.ir_if_id = i_op(6'h09, 0, 1, 16'd5);
        tick();
        chk("pre_rst_reg_wr", 32'(bus.reg_wr_id_ex), 32'd1);
        bus.ir_if_id = 32'h0800_0010;
        #1;
        chk("pre_rst_jump", 32'(bus.jump), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reg_wr", 32'(bus.reg_wr_id_ex), 32'd0);
        chk("async_dst",    32'(bus.dst_id_ex), 32'd0);
        chk("async_imm",    bus.imm_id_ex, 32'd0);
        chk("async_jump",   32'(bus.jump), 32'd0);
        tick();
        bus.ir_if_id = r_op(2, 5, 3, 0, 6'h21);
        rst_n = 1'b1;
        tick();
        chk("rf_clr_rs", bus.rs_id_ex, 32'h0);
        chk("rf_clr_rt", bus.rt_id_ex, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- Second pipeline stage of the MIPS core. Sits directly downstream of instruction fetch.
- Consumes the IF/ID pair pc_if_id/ir_if_id.
- Owns the 32x32 register file and decodes control signals into the ID/EX pipeline registers.
- Resolves jumps and branches, driving jump/addr back to fetch. Architectural branch delay slot: the instruction fetched alongside a taken branch always executes.

Parameters:
WORD_SIZE, 32, datapath and PC width
LINK_REG, 31, destination register written by JAL

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
pc_if_id  in  WORD_SIZE  word address of ir_if_id plus one
ir_if_id  in  32  instruction word; 0 = NOP
wb_en  in  1  writeback enable
wb_reg  in  5  writeback register index
wb_data  in  WORD_SIZE  writeback value
jump  out  1  combinational redirect request to fetch
addr  out  WORD_SIZE  combinational redirect word address
pc_id_ex  out  WORD_SIZE  registered pc_if_id
rs_id_ex, rt_id_ex  out  WORD_SIZE  registered operand values
imm_id_ex  out  WORD_SIZE  registered extended immediate / shamt
dst_id_ex  out  5  registered destination index (0 = none)
alu_op_id_ex  out  4  registered ALU operation (package enum)
alu_src_id_ex  out  1  1 = B operand is imm_id_ex
mem_rd_id_ex, mem_wr_id_ex, reg_wr_id_ex, mem_to_reg_id_ex, link_id_ex  out  1 each  registered control
illegal  out  1  registered, one-cycle pulse per undecodable instruction

Behaviour:
- Reset (rst_n low, asynchronous): all *_id_ex outputs, illegal and all 32 registers clear to 0. jump forced 0 while rst_n low. First edge after release latches the decode of the current ir_if_id.
- Register file:
  - 2 combinational reads (rs = ir[25:21], rt = ir[20:16]), 1 synchronous write.
  - Writes with wb_reg==0 are ignored; r0 always reads 0.
  - Write-to-read bypass: if wb_en and wb_reg==index and index!=0, the read returns wb_data in the same cycle.
- ID/EX: every rising edge latches the decode of ir_if_id. Latency 1 cycle. No stall or flush inputs. Load-use and EX/MEM forwarding are handled by software scheduling (one load delay slot).
- Decoded set:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR.
  - I-type: ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
- Immediates:
  - Sign-extended for ADDIU, SLTI, SLTIU, LW, SW, branches.
  - Zero-extended for ANDI, ORI, XORI.
  - LUI: imm<<16.
  - Shifts: imm_id_ex = zero-extended shamt, alu_src=1.
- Destination: rd for R-type ALU ops, rt for I-type ALU ops and LW, LINK_REG for JAL; 0 with reg_wr=0 for SW, branches, J, JR.
- Redirect (combinational from ir_if_id and bypassed reads):
  - BEQ taken when rs==rt; BNE taken when rs!=rt. addr = pc_if_id + sext(imm16), modulo 2^WORD_SIZE.
  - J/JAL: addr = {pc_if_id[WORD_SIZE-1:26], ir[25:0]}.
  - JR: addr = rs value.
  - jump=1 only for taken branch, J, JAL, JR. Otherwise jump=0 and addr=0.
- JAL: link_id_ex=1, reg_wr=1, and the value presented on rs_id_ex is pc_if_id+1 (return past the delay slot).
- Illegal or unsupported encodings: latched as a bubble (all control 0, dst 0), illegal=1 for that cycle, jump=0.
- All-zero instruction decodes as SLL r0,r0,0. It is legal and harmless (dst 0, reg_wr 0).
- Reset asserted mid-stream discards the in-flight decode. No partial register write occurs on the reset edge.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - 4-bit ALU op enum: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI;
  - LINK_REG default.
- One sub-module: regfile (2R1W, async-clear, write bypass). Decode logic and ID/EX registers live in decode.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ir=ADDIU r1,r0,5 → all outputs 0, jump=0. Release → next edge gives reg_wr=1, dst=1, imm=5, alu_op=ADD.
- Writeback bypass: wb r2=0x1234 while ir=ADDU r3,r2,r0 in the same cycle → rs_id_ex=0x1234. Then wb_reg=0 with 0xFFFF → r0 still reads 0.
- BEQ r1,r1,-2 at pc_if_id=0x10 → jump=1, addr=0x0E. BNE r1,r1 with the same offset → jump=0.
- JAL target 0x3FFFFFF at pc_if_id=0x04000001 → addr=0x07FFFFFF, dst=31, rs_id_ex=0x04000002. JR r5 (r5=0x40) → addr=0x40.
- ORI r4,r0,0x8000 → imm=0x00008000. ADDIU with 0x8000 → imm=0xFFFF8000. LUI 0xABCD → imm=0xABCD0000.
- Opcode 0x3F → illegal=1 for one cycle, reg_wr/mem_wr/mem_rd=0, jump=0. Assert rst_n low mid-sequence → outputs clear immediately, before the clock edge.
